// File: rtl/pif_ram_arbiter_pkg.sv
// Shared definitions for the PIF RAM arbiter and the serial PIF engine:
// arbiter state encoding, RAM geometry and big-endian byte-lane helpers.
package pif_ram_arbiter_pkg;

    localparam int PIF_ADDR_W = 9;
    localparam int WORD_W     = 32;
    localparam int LANE_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SER_WAIT = 2'd1,
        ST_CPU_WAIT = 2'd2,
        ST_CPU_WR   = 2'd3
    } arb_state_t;

    // Lane k occupies bits [31-8k -: 8]; lane 0 is the most significant byte.
    function automatic logic [LANE_W-1:0] lane_extract(input logic [WORD_W-1:0] word,
                                                       input logic [1:0]        lane);
        logic [LANE_W-1:0] b;
        case (lane)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [WORD_W-1:0] lane_insert(input logic [WORD_W-1:0] word,
                                                      input logic [1:0]        lane,
                                                      input logic [LANE_W-1:0] lane_byte);
        logic [WORD_W-1:0] w;
        w = word;
        case (lane)
            2'd0:    w[31:24] = lane_byte;
            2'd1:    w[23:16] = lane_byte;
            2'd2:    w[15:8]  = lane_byte;
            default: w[7:0]   = lane_byte;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pif_ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the RAM macro.
//
// Handshakes: a requester raises *_req with its fields and holds them stable
// until the arbiter answers (ser_gnt for serial, cpu_ack for CPU); both answers
// are single-cycle pulses and the requester drops req in the following cycle.
// ser_rvalid / cpu_ack qualify their read data for exactly that cycle.
interface pif_ram_arbiter_if
    import pif_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = PIF_ADDR_W
);
    // serial PIF engine (word requester)
    logic                ser_req;
    logic                ser_wren;
    logic [ADDR_W-1:0]   ser_addr;
    logic [WORD_W-1:0]   ser_wdata;
    logic                ser_gnt;
    logic                ser_rvalid;
    logic [WORD_W-1:0]   ser_rdata;
    // local CPU (byte requester)
    logic                cpu_req;
    logic                cpu_wren;
    logic [ADDR_W+1:0]   cpu_addr;
    logic [LANE_W-1:0]   cpu_wdata;
    logic                cpu_ack;
    logic [LANE_W-1:0]   cpu_rdata;
    // RAM macro
    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_wren;
    logic [WORD_W-1:0]   ram_wdata;
    logic [WORD_W-1:0]   ram_rdata;

    modport slave (
        input  ser_req, ser_wren, ser_addr, ser_wdata,
        output ser_gnt, ser_rvalid, ser_rdata,
        input  cpu_req, cpu_wren, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        output ram_addr, ram_wren, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output ser_req, ser_wren, ser_addr, ser_wdata,
        input  ser_gnt, ser_rvalid, ser_rdata,
        output cpu_req, cpu_wren, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        input  ram_addr, ram_wren, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/pif_ram_arbiter_lane_merge.sv
// Byte-lane datapath for CPU accesses: extracts the addressed byte from a RAM
// word and builds the read-modify-write word with that byte replaced.
module pif_ram_arbiter_lane_merge
    import pif_ram_arbiter_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        lane,
    input  logic [LANE_W-1:0] wr_byte,
    output logic [WORD_W-1:0] merged,
    output logic [LANE_W-1:0] rd_byte
);

    // Pure lane steering, no state.
    always_comb begin
        merged  = lane_insert(word, lane, wr_byte);
        rd_byte = lane_extract(word, lane);
    end

endmodule

// File: rtl/pif_ram_arbiter.sv
// Arbiter for the single-port PIF RAM. The serial engine has priority; the CPU
// wins when serial is idle or disabled, or after waiting STARVE_MAX cycles.
// CPU byte writes are read-modify-write and hold the RAM until the write lands.
module pif_ram_arbiter
    import pif_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = PIF_ADDR_W,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic                             clk,
    input  logic                             reset_l,
    input  logic                             pif_disable,
    pif_ram_arbiter_if.slave                 bus,
    output logic                             busy,
    output logic                             owner,
    output arb_state_t                       dbg_state,
    output logic [$clog2(STARVE_MAX+1)-1:0]  dbg_starve_cnt
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam int LAT_W = $clog2(RAM_LAT + 1);

    arb_state_t        state;
    logic [LAT_W-1:0]  lat_cnt;
    logic [CNT_W-1:0]  starve_cnt;
    logic              ser_is_rd;
    logic              cpu_is_wr;
    logic [1:0]        cpu_lane;
    logic [LANE_W-1:0] cpu_byte;
    logic [WORD_W-1:0] merged_word;
    logic [LANE_W-1:0] extracted_byte;
    logic              cpu_req_eff;
    logic              cpu_serving;
    logic              cpu_wins;
    logic              ser_wins;

    pif_ram_arbiter_lane_merge u_lane_merge (
        .word    (bus.ram_rdata),
        .lane    (cpu_lane),
        .wr_byte (cpu_byte),
        .merged  (merged_word),
        .rd_byte (extracted_byte)
    );

    // Grant decision; a CPU read acks in an IDLE cycle, so its still-high req
    // in that cycle belongs to the finished access and is masked out.
    always_comb begin
        cpu_req_eff = bus.cpu_req & ~bus.cpu_ack;
        cpu_serving = (state == ST_CPU_WAIT) || (state == ST_CPU_WR);
        cpu_wins    = (state == ST_IDLE) && cpu_req_eff &&
                      (pif_disable || !bus.ser_req || (starve_cnt == CNT_W'(STARVE_MAX)));
        ser_wins    = (state == ST_IDLE) && !cpu_wins && bus.ser_req && !pif_disable;
    end

    // Starvation counter: counts cycles the CPU waits for a grant, saturating.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            starve_cnt <= '0;
        end else if (cpu_wins) begin
            starve_cnt <= '0;
        end else if (cpu_req_eff && !cpu_serving && (starve_cnt != CNT_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Arbiter FSM with registered RAM controls and requester responses.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state          <= ST_IDLE;
            lat_cnt        <= '0;
            ser_is_rd      <= 1'b0;
            cpu_is_wr      <= 1'b0;
            cpu_lane       <= 2'd0;
            cpu_byte       <= '0;
            owner          <= 1'b0;
            bus.ram_addr   <= '0;
            bus.ram_wren   <= 1'b0;
            bus.ram_wdata  <= '0;
            bus.ser_gnt    <= 1'b0;
            bus.ser_rvalid <= 1'b0;
            bus.ser_rdata  <= '0;
            bus.cpu_ack    <= 1'b0;
            bus.cpu_rdata  <= '0;
        end else begin
            bus.ser_gnt    <= 1'b0;
            bus.ser_rvalid <= 1'b0;
            bus.cpu_ack    <= 1'b0;
            bus.ram_wren   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_wins) begin
                        owner        <= 1'b1;
                        bus.ram_addr <= bus.cpu_addr[ADDR_W+1:2];
                        cpu_lane     <= bus.cpu_addr[1:0];
                        cpu_byte     <= bus.cpu_wdata;
                        cpu_is_wr    <= bus.cpu_wren;
                        lat_cnt      <= LAT_W'(RAM_LAT);
                        state        <= ST_CPU_WAIT;
                    end else if (ser_wins) begin
                        owner        <= 1'b0;
                        bus.ser_gnt  <= 1'b1;
                        bus.ram_addr <= bus.ser_addr;
                        if (bus.ser_wren) begin
                            bus.ram_wren  <= 1'b1;
                            bus.ram_wdata <= bus.ser_wdata;
                            ser_is_rd     <= 1'b0;
                            lat_cnt       <= '0;
                        end else begin
                            ser_is_rd     <= 1'b1;
                            lat_cnt       <= LAT_W'(RAM_LAT);
                        end
                        state <= ST_SER_WAIT;
                    end
                end
                ST_SER_WAIT: begin
                    if (lat_cnt == '0) begin
                        if (ser_is_rd) begin
                            bus.ser_rvalid <= 1'b1;
                            bus.ser_rdata  <= bus.ram_rdata;
                        end
                        state <= ST_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                ST_CPU_WAIT: begin
                    if (lat_cnt == '0) begin
                        bus.cpu_ack   <= 1'b1;
                        bus.cpu_rdata <= extracted_byte;
                        if (cpu_is_wr) begin
                            bus.ram_wren  <= 1'b1;
                            bus.ram_wdata <= merged_word;
                            state         <= ST_CPU_WR;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = (state != ST_IDLE);
    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

endmodule
